// File: rtl/gf_pkg.sv
// Shared defaults and FSM state type for the GF(2^M) digit-serial multiplier.
package gf_pkg;

    localparam int         GF_M_DEF    = 8;
    localparam logic [8:0] GF_POLY_DEF = 9'h11D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } gf_state_e;

endpackage

// File: rtl/gf_mul_digit.sv
// One digit-serial step in GF(2^M): acc_next = acc*x^DIGIT + a*digit mod POLY.
module gf_mul_digit
    import gf_pkg::*;
#(
    parameter int         M     = GF_M_DEF,
    parameter logic [M:0] POLY  = (M+1)'(GF_POLY_DEF),
    parameter int         DIGIT = 2
) (
    input  logic [M-1:0]     acc,
    input  logic [M-1:0]     a,
    input  logic [DIGIT-1:0] digit,
    output logic [M-1:0]     acc_next
);

    function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY[M-1:0] : '0);
    endfunction

    logic [M-1:0] r;

    // Horner over the digit bits, MSB first: shift-reduce, then add a if the bit is set.
    always_comb begin
        r = acc;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            r = xtime(r) ^ (digit[i] ? a : '0);
        end
        acc_next = r;
    end

endmodule

// File: rtl/gf_mul_serial.sv
// Digit-serial GF(2^M) multiplier with valid/ready handshakes on both sides.
// Define GF_MUL_ACC_EN to add in_acc: prod = A*B XOR previous prod when set.
module gf_mul_serial
    import gf_pkg::*;
#(
    parameter int         M     = GF_M_DEF,
    parameter logic [M:0] POLY  = (M+1)'(GF_POLY_DEF),
    parameter int         DIGIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] mul_A,
    input  logic [M-1:0] mul_B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] prod
`ifdef GF_MUL_ACC_EN
    ,
    input  logic         in_acc
`endif
);

    if (M < 2 || M > 16) begin : g_bad_m
        $error("gf_mul_serial: M must be in 2..16");
    end
    if (DIGIT < 1 || DIGIT > M || (M % DIGIT) != 0) begin : g_bad_digit
        $error("gf_mul_serial: DIGIT must divide M");
    end
    if (POLY[M] != 1'b1) begin : g_bad_poly
        $error("gf_mul_serial: POLY bit M must be set");
    end

    localparam int NDIG  = M / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    gf_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [M-1:0]     a_reg, b_reg, acc, acc_step;
    logic             accept, acc_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_CALC;
            end
            ST_CALC: begin
                if (cnt == '0) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    in_ready  = 1'b1;
                    state_nxt = in_valid ? ST_CALC : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);

    gf_mul_digit #(
        .M     (M),
        .POLY  (POLY),
        .DIGIT (DIGIT)
    ) u_step (
        .acc      (acc),
        .a        (a_reg),
        .digit    (b_reg[M-1 -: DIGIT]),
        .acc_next (acc_step)
    );

`ifdef GF_MUL_ACC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         acc_mode <= 1'b0;
        else if (accept) acc_mode <= in_acc;
    end
`else
    assign acc_mode = 1'b0;
`endif

    // B is shifted left each step so its unconsumed digit always sits at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            prod  <= '0;
        end else if (accept) begin
            a_reg <= mul_A;
            b_reg <= mul_B;
            acc   <= '0;
            cnt   <= CNT_LAST;
        end else if (state == ST_CALC) begin
            acc   <= acc_step;
            b_reg <= b_reg << DIGIT;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == '0) prod <= acc_step ^ (acc_mode ? prod : '0);
        end
    end

endmodule

// File: tb/tb_gf_mul_serial.sv
// Directed and swept checks of gf_mul_serial in GF(2^8), POLY 0x11D.
module tb_gf_mul_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mul_A, mul_B;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] prod;
`ifdef GF_MUL_ACC_EN
    logic       in_acc;
    logic       sw_acc;
`endif

    logic       sw_valid;
    logic       sw_out_ready;
    logic [7:0] sw_a, sw_b;
    logic       sw_in_ready  [4];
    logic       sw_out_valid [4];
    logic [7:0] sw_prod      [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gf_mul_serial #(.M(8), .POLY(9'h11D), .DIGIT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_A     (mul_A),
        .mul_B     (mul_B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod)
`ifdef GF_MUL_ACC_EN
        ,
        .in_acc    (in_acc)
`endif
    );

    for (genvar g = 0; g < 4; g++) begin : g_sw
        gf_mul_serial #(.M(8), .POLY(9'h11D), .DIGIT(1 << g)) u_sw (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sw_valid),
            .in_ready  (sw_in_ready[g]),
            .mul_A     (sw_a),
            .mul_B     (sw_b),
            .out_valid (sw_out_valid[g]),
            .out_ready (sw_out_ready),
            .prod      (sw_prod[g])
`ifdef GF_MUL_ACC_EN
            ,
            .in_acc    (sw_acc)
`endif
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // LSB-first shift-and-add reference in GF(2^8) mod 0x11D.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, aa;
        r  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
        end
        return r;
    endfunction

    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        mul_A    = a;
        mul_B    = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp);
        int lat;
        chk({tag, " in_ready"}, in_ready, 1);
        issue(a, b);
        wait_result(lat);
        chk({tag, " latency"}, lat, 4);
        chk({tag, " prod"}, prod, exp);
        @(posedge clk); #1;
        chk({tag, " out_valid drop"}, out_valid, 0);
        chk({tag, " prod hold"}, prod, exp);
    endtask

    initial begin
        int         lat;
        int         lat_sw [4];
        logic [7:0] got_sw [4];
        logic [7:0] va, vb;

        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        mul_A        = 8'h00;
        mul_B        = 8'h00;
        sw_valid     = 1'b0;
        sw_out_ready = 1'b1;
        sw_a         = 8'h00;
        sw_b         = 8'h00;
`ifdef GF_MUL_ACC_EN
        in_acc       = 1'b0;
        sw_acc       = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset prod", prod, 8'h00);
        chk("reset in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("x*x^7", 8'h02, 8'h80, 8'h1D);
        run_op("x*inv", 8'h02, 8'h8E, 8'h01);
        run_op("ff*1", 8'hFF, 8'h01, 8'hFF);
        run_op("a zero", 8'h00, 8'hA7, 8'h00);
        run_op("b zero", 8'hA7, 8'h00, 8'h00);

        // Output backpressure with a pending pair, then same-edge acceptance.
        out_ready = 1'b0;
        issue(8'h02, 8'h80);
        wait_result(lat);
        chk("bp latency", lat, 4);
        chk("bp prod", prod, 8'h1D);
        mul_A    = 8'hFF;
        mul_B    = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp hold prod", prod, 8'h1D);
            chk("bp hold out_valid", out_valid, 1);
            chk("bp hold in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b out_valid drop", out_valid, 0);
        wait_result(lat);
        chk("b2b latency", lat, 4);
        chk("b2b prod", prod, 8'hFF);
        @(posedge clk); #1;

        // Reset in the middle of a calculation.
        issue(8'h02, 8'h8E);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst prod", prod, 8'h00);
        chk("mid rst in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("dropped op no result", out_valid, 0);
        end
        run_op("after rst", 8'h02, 8'h8E, 8'h01);

`ifdef GF_MUL_ACC_EN
        in_acc = 1'b0;
        run_op("mac plain", 8'h02, 8'h80, 8'h1D);
        in_acc = 1'b1;
        run_op("mac acc", 8'h02, 8'h8E, 8'h1C);
        in_acc = 1'b0;
`endif

        // Sweep all legal digit widths against the reference model.
        for (int v = 0; v < 8; v++) begin
            va = (v == 0) ? 8'h80 : 8'($urandom_range(0, 255));
            vb = (v == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("sweep d%0d in_ready", 1 << g), sw_in_ready[g], 1);
                lat_sw[g] = -1;
                got_sw[g] = 8'h00;
            end
            sw_a     = va;
            sw_b     = vb;
            sw_valid = 1'b1;
            @(posedge clk); #1;
            sw_valid = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                @(posedge clk); #1;
                for (int g = 0; g < 4; g++) begin
                    if (sw_out_valid[g] && lat_sw[g] < 0) begin
                        lat_sw[g] = c;
                        got_sw[g] = sw_prod[g];
                    end
                end
            end
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("sweep d%0d %02h*%02h latency", 1 << g, va, vb), lat_sw[g], 8 >> g);
                chk($sformatf("sweep d%0d %02h*%02h prod", 1 << g, va, vb), got_sw[g], ref_mul(va, vb));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
